pwm_decoder: RTL and testbench

- Receive-side counterpart of the team's PWM generator. It samples a PWM waveform on the shared `step` strobe and recovers the N-bit duty code the generator was driven with.
- Also flags non-PWM waveforms (more than one pulse per period).
- Declares lock once two consecutive periods decode to the same value.
- Used in loopback self-test and to read PWM-encoded sensor and control inputs.

---
 rtl/pwm_decoder.sv | 146 ++++++++++++++
 tb/tb_pwm_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_decoder.sv
// PWM decoder: recovers the N-bit duty code from a PWM waveform sampled on step,
// flags multi-pulse windows and declares lock after two equal clean windows.
module pwm_decoder #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         step,
    input  logic         pwm_in,
    output logic [N-1:0] duty,
    output logic         valid,
    output logic         glitch,
    output logic         locked
);

    localparam int unsigned HW = N + 1;

    typedef enum logic [1:0] {
        SEEK  = 2'd0,
        CHECK = 2'd1,
        LOCK  = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            locked_d;
    logic [N-1:0]    ref_duty;
    logic [N-1:0]    ref_d;

    logic            s1;
    logic            s2;
    logic            prev_sample;
    logic [N-1:0]    win_cnt;
    logic [HW-1:0]   high_cnt;
    logic [1:0]      edge_cnt;

    logic            sample;
    logic            rise;
    logic            win_end;
    logic            match;
    logic [HW-1:0]   high_fin;
    logic [1:0]      edge_fin;
    logic [N-1:0]    duty_fin;
    logic            glitch_fin;

    // Closing-window values include the window-end sample itself
    always_comb begin
        sample     = step & ena;
        rise       = s2 & ~prev_sample;
        win_end    = sample && (win_cnt == {N{1'b1}});
        high_fin   = high_cnt + HW'(s2);
        edge_fin   = (rise && (edge_cnt != 2'd3)) ? edge_cnt + 2'd1 : edge_cnt;
        duty_fin   = (high_fin <= HW'(1)) ? '0 : N'(high_fin - HW'(1));
        glitch_fin = (edge_fin > 2'd1);
        match      = (duty_fin == ref_duty);
    end

    // Two-flop synchroniser; keeps running while ena is low
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
        end
    end

    // Window measurement datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            win_cnt     <= '0;
            high_cnt    <= '0;
            edge_cnt    <= '0;
            prev_sample <= 1'b0;
            duty        <= '0;
            glitch      <= 1'b0;
            valid       <= 1'b0;
        end else if (!ena) begin
            win_cnt     <= '0;
            high_cnt    <= '0;
            edge_cnt    <= '0;
            prev_sample <= 1'b0;
            valid       <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (sample) begin
                prev_sample <= s2;
                win_cnt     <= win_cnt + N'(1);
                if (win_end) begin
                    high_cnt <= '0;
                    edge_cnt <= '0;
                    duty     <= duty_fin;
                    glitch   <= glitch_fin;
                    valid    <= 1'b1;
                end else begin
                    high_cnt <= high_fin;
                    edge_cnt <= edge_fin;
                end
            end
        end
    end

    // Lock FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SEEK;
            locked   <= 1'b0;
            ref_duty <= '0;
        end else begin
            state_q  <= state_d;
            locked   <= locked_d;
            ref_duty <= ref_d;
        end
    end

    // Lock FSM: next state, evaluated only at window end
    always_comb begin
        state_d = state_q;
        if (!ena) begin
            state_d = SEEK;
        end else if (win_end) begin
            if (glitch_fin) begin
                state_d = SEEK;
            end else begin
                case (state_q)
                    SEEK:    state_d = CHECK;
                    CHECK:   state_d = match ? LOCK : CHECK;
                    LOCK:    state_d = match ? LOCK : CHECK;
                    default: state_d = SEEK;
                endcase
            end
        end
    end

    // Lock FSM: outputs; ref tracks the latest clean duty
    always_comb begin
        locked_d = (state_d == LOCK);
        ref_d    = ref_duty;
        if (ena && win_end && !glitch_fin) begin
            ref_d = duty_fin;
        end
    end

endmodule

// File: tb/tb_pwm_decoder.sv
// Directed self-checking bench for pwm_decoder (N=8, step every 4 clocks).
module tb_pwm_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       step;
    logic       pwm_in;
    logic [7:0] duty;
    logic       valid;
    logic       glitch;
    logic       locked;

    int         checks   = 0;
    int         failures = 0;

    int         mode;        // 0 low, 1 high, 2 generator, 3 double pulse
    logic [7:0] gcnt;
    logic [7:0] gduty;
    logic [7:0] wpos;
    int         nvalid;
    logic [7:0] cap_duty;
    logic       cap_glitch;
    logic       cap_locked;

    pwm_decoder #(.N(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .step   (step),
        .pwm_in (pwm_in),
        .duty   (duty),
        .valid  (valid),
        .glitch (glitch),
        .locked (locked)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic src();
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return (gduty != 8'd0) && (gcnt <= gduty);
            default: return ((wpos >= 8'd10) && (wpos < 8'd20)) ||
                            ((wpos >= 8'd100) && (wpos < 8'd110));
        endcase
    endfunction

    // One step slot: drive pwm_in, pulse step 3 clocks later, capture any valid
    task automatic do_steps(input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = src();
            repeat (3) @(negedge clk);
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            if (valid) begin
                nvalid++;
                cap_duty   = duty;
                cap_glitch = glitch;
                cap_locked = locked;
            end
            gcnt++;
            wpos++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        ena  = 1'b1;
        step = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pwm_in = ~pwm_in;
            @(negedge clk);
        end
        chk("rst_duty", 32'(duty), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_glitch", 32'(glitch), 0);
        chk("rst_locked", 32'(locked), 0);
        rst    = 1'b0;
        step   = 1'b0;
        wpos   = 8'd0;
        nvalid = 0;
    endtask

    initial begin
        rst = 1'b1; ena = 1'b1; step = 1'b0; pwm_in = 1'b0;
        mode = 0; gcnt = 8'd0; gduty = 8'd100; wpos = 8'd0; nvalid = 0;
        cap_duty = 8'd0; cap_glitch = 1'b0; cap_locked = 1'b0;
        repeat (2) @(negedge clk);

        // Reset, then constant low: first valid only after step 256
        do_reset();
        mode = 0;
        do_steps(255);
        chk("lo_no_valid_255", 32'(nvalid), 0);
        do_steps(1);
        chk("lo_valid_256", 32'(nvalid), 1);
        chk("lo_w1_duty", 32'(cap_duty), 0);
        chk("lo_w1_glitch", 32'(cap_glitch), 0);
        chk("lo_w1_locked", 32'(cap_locked), 0);
        do_steps(256);
        chk("lo_w2_valid", 32'(nvalid), 2);
        chk("lo_w2_duty", 32'(cap_duty), 0);
        chk("lo_w2_locked", 32'(cap_locked), 1);

        // Constant high decodes to full scale without overflow
        do_reset();
        mode = 1;
        do_steps(256);
        chk("hi_w1_duty", 32'(cap_duty), 255);
        chk("hi_w1_glitch", 32'(cap_glitch), 0);
        chk("hi_w1_locked", 32'(cap_locked), 0);
        do_steps(256);
        chk("hi_w2_duty", 32'(cap_duty), 255);
        chk("hi_w2_glitch", 32'(cap_glitch), 0);
        chk("hi_w2_locked", 32'(cap_locked), 1);

        // Generator at duty 100, decoder starting in the low phase
        do_reset();
        mode  = 2;
        gduty = 8'd100;
        gcnt  = 8'($urandom_range(101, 178));
        do_steps(256);
        chk("gen_w1_duty", 32'(cap_duty), 100);
        chk("gen_w1_glitch", 32'(cap_glitch), 0);
        chk("gen_w1_locked", 32'(cap_locked), 0);
        do_steps(256);
        chk("gen_w2_duty", 32'(cap_duty), 100);
        chk("gen_w2_locked", 32'(cap_locked), 1);
        do_steps(256);
        chk("gen_w3_duty", 32'(cap_duty), 100);
        chk("gen_w3_locked", 32'(cap_locked), 1);

        // Duty change mid-window: mixed window reads 50, lock drops then returns
        do_steps(128);
        gduty = 8'd50;
        do_steps(128);
        chk("chg_mix_duty", 32'(cap_duty), 50);
        chk("chg_mix_locked", 32'(cap_locked), 0);
        chk("chg_mix_glitch", 32'(cap_glitch), 0);
        do_steps(256);
        chk("chg_w2_duty", 32'(cap_duty), 50);
        chk("chg_w2_locked", 32'(cap_locked), 1);

        // Two pulses in one window: glitch, back to SEEK, relock needs two windows
        mode = 3;
        wpos = 8'd0;
        do_steps(256);
        chk("gl_duty", 32'(cap_duty), 19);
        chk("gl_glitch", 32'(cap_glitch), 1);
        chk("gl_locked", 32'(cap_locked), 0);
        mode = 0;
        do_steps(256);
        chk("gl_clean1_glitch", 32'(cap_glitch), 0);
        chk("gl_clean1_locked", 32'(cap_locked), 0);
        do_steps(256);
        chk("gl_clean2_duty", 32'(cap_duty), 0);
        chk("gl_clean2_locked", 32'(cap_locked), 1);

        // Lock at 255, then drop ena mid-window
        mode = 1;
        do_steps(256);
        chk("en_pre1_locked", 32'(cap_locked), 0);
        do_steps(256);
        chk("en_pre2_locked", 32'(cap_locked), 1);
        mode   = 0;
        nvalid = 0;
        do_steps(200);
        ena = 1'b0;
        repeat (20) @(negedge clk);
        chk("en_low_duty_hold", 32'(duty), 255);
        chk("en_low_locked", 32'(locked), 0);
        chk("en_low_valid", 32'(valid), 0);
        ena  = 1'b1;
        wpos = 8'd0;
        do_steps(255);
        chk("en_no_valid", 32'(nvalid), 0);
        do_steps(1);
        chk("en_valid_256", 32'(nvalid), 1);
        chk("en_w1_duty", 32'(cap_duty), 0);
        chk("en_w1_locked", 32'(cap_locked), 0);
        do_steps(256);
        chk("en_w2_locked", 32'(cap_locked), 1);

        // ena falls exactly on the window-end step: no valid, lock dropped
        nvalid = 0;
        do_steps(255);
        ena = 1'b0;
        do_steps(1);
        chk("en_edge_no_valid", 32'(nvalid), 0);
        chk("en_edge_locked", 32'(locked), 0);
        ena  = 1'b1;
        wpos = 8'd0;
        do_steps(256);
        chk("en_edge_recover_valid", 32'(nvalid), 1);
        chk("en_edge_recover_locked", 32'(cap_locked), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
